serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
//
// PURPOSE
//   Sequencer for a bit-serial WIDTH-bit subtractor built from two chained
//   half-subtractor cells (d = x^y, b = ~x&y) plus a borrow register.
//   Loads operands on a start handshake and steps the cell LSB-first, one bit
//   per clock. Reports difference and final borrow with a one-cycle done pulse.
//   Sits between a requesting datapath and the shared half-subtractor cells.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 2..32
//
// PORTS
//   clk     input   1      rising-edge clock
//   rst     input   1      asynchronous, active-high reset
//   start   input   1      request; sampled only in IDLE
//   a       input   WIDTH  minuend, captured on accepted start
//   b       input   WIDTH  subtrahend, captured on accepted start
//   busy    output  1      high while in SHIFT
//   done    output  1      one-cycle pulse in DONE state
//   diff    output  WIDTH  a - b mod 2^WIDTH; valid from done, held until next accept
//   borrow  output  1      1 when a < b (unsigned); valid/held like diff
//
// BEHAVIOUR
//   - Reset (async assert, any state): state=IDLE; busy=0, done=0, diff=0,
//     borrow=0; operand shift regs, borrow reg, bit counter cleared.
//   - States: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: start=1 at edge -> capture a,b; borrow reg=0; cnt=0; go SHIFT.
//     start=0 -> stay. diff/borrow keep last result.
//   - SHIFT: per cycle, with ai=a_sr[0], bi=b_sr[0], br=borrow reg:
//       h1: d1=ai^bi, b1=~ai&bi;  h2: dout=d1^br, b2=~d1&br
//       result bit = dout shifted in at MSB of diff shift reg; br <= b1|b2;
//       a_sr, b_sr shift right; cnt++. When cnt==WIDTH-1 -> DONE.
//   - Exactly WIDTH SHIFT cycles; done asserts on the cycle after the last
//     SHIFT cycle. Latency start-accept edge to done high: WIDTH+1 clocks.
//   - DONE: done=1 one cycle; diff/borrow outputs update at DONE entry
//     (not visible mid-operation); unconditionally -> IDLE.
//   - start while SHIFT or DONE: ignored, not queued. Earliest re-accept is the
//     first IDLE cycle after DONE (back-to-back issue every WIDTH+2 clocks).
//   - a/b changes after accept do not affect the operation in flight.
//   - Reset mid-SHIFT: operation abandoned, no done pulse, outputs zero.
//   - busy=0 and done=0 in IDLE; busy and done never high together.
//   - Arithmetic is unsigned, wraps mod 2^WIDTH; borrow = final borrow reg.
//
// CONFIGURATION
//   SERIAL_SUB_SAT_EN defined: if final borrow=1, diff presented as all-zeros
//     (floor-saturating subtract); borrow still reports 1.
//   SERIAL_SUB_SAT_EN undefined: diff is raw wrapped result; no extra logic.
//
// TESTING
//   1. WIDTH=8, a=100, b=37, start 1 cycle -> busy 8 cycles, done at +9 clocks,
//      diff=63, borrow=0.
//   2. a=0x00, b=0x01 -> diff=0xFF, borrow=1; with SERIAL_SUB_SAT_EN
//      diff=0x00, borrow=1.
//   3. a=0x5A, b=0x5A -> diff=0x00, borrow=0; a=0xFF, b=0x00 -> diff=0xFF, borrow=0.
//   4. start held high continuously, a=9, b=4 -> results every 10 clocks,
//      diff=5; start pulses mid-SHIFT and in DONE produce no extra done.
//   5. Change a/b during SHIFT -> result reflects captured operands only.
//   6. Assert rst at 4th SHIFT cycle -> outputs 0 immediately (async), no done;
//      after release new start completes normally.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: sequencer for a bit-serial WIDTH-bit subtractor.
// Two chained half-subtractor cells plus a borrow register process one bit per
// clock, LSB first. A start in IDLE captures the operands. The result is
// published with a one-cycle done pulse after exactly WIDTH shift cycles.
//
// Optional build macro:
//   SERIAL_SUB_SAT_EN - floor-saturate: present diff as zero when the final
//                       borrow is set. borrow still reports 1.

module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    // Half-subtractor cell outputs for the current bit.
    logic             ai, bi;
    logic             d1, b1;
    logic             dout, b2;
    logic             br_next;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] result;

    // Two chained half-subtractors: operand bits first, then the running borrow.
    always_comb begin
        ai      = a_sr_q[0];
        bi      = b_sr_q[0];
        d1      = ai ^ bi;
        b1      = ~ai & bi;
        dout    = d1 ^ br_q;
        b2      = ~d1 & br_q;
        br_next = b1 | b2;
        // The result bit enters at the MSB, so after WIDTH shifts bit 0 lands at LSB.
        sr_next = {dout, diff_sr_q[WIDTH-1:1]};
`ifdef SERIAL_SUB_SAT_EN
        result  = br_next ? '0 : sr_next;
`else
        result  = sr_next;
`endif
    end

    // Next-state and next-output logic. Outputs are registered, so busy and
    // done follow the state being entered.
    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        br_d      = br_q;
        cnt_d     = cnt_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        diff_d    = diff_q;
        borrow_d  = borrow_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d    = a;
                    b_sr_d    = b;
                    diff_sr_d = '0;
                    br_d      = 1'b0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
                diff_sr_d = sr_next;
                br_d      = br_next;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    // Publish the result only here, so it is never visible mid-operation.
                    diff_d   = result;
                    borrow_d = br_next;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else begin
                    busy_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Register all state and outputs. Reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            br_q      <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            br_q      <= br_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            diff_q    <= diff_d;
            borrow_q  <= borrow_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8): vector table plus corner sequences.
// Honours SERIAL_SUB_SAT_EN in its expectations.

module tb_serial_sub_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_diff = '0;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] raw_diff;
        logic         exp_borrow;
    } vec_t;

    vec_t vecs[8];

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sat(input logic [W-1:0] d, input logic br);
`ifdef SERIAL_SUB_SAT_EN
        return br ? '0 : d;
`else
        return d;
`endif
    endfunction

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (!rst && busy && done) begin
            chk("busy_done_exclusive", 32'(busy & done), 32'd0);
        end
    end

    // One start handshake followed by checks on latency, busy length, the held result and the final result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] exp_d, input logic exp_b, input string nm);
        int lat;
        int busy_n;
        bit seen;
        lat    = 0;
        busy_n = 0;
        seen   = 0;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= 20 && !seen; t++) begin
            if (busy) busy_n++;
            if (t == 4) chk({nm, "_held_diff"}, 32'(diff), 32'(last_diff));
            if (done) begin
                seen = 1;
                lat  = t;
            end
            if (!seen) @(negedge clk);
        end
        if (!seen) begin
            chk({nm, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, "_latency"}, 32'(lat), 32'(W + 1));
            chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(W));
            chk({nm, "_diff"}, 32'(diff), 32'(exp_d));
            chk({nm, "_borrow"}, 32'(borrow), 32'(exp_b));
        end
        last_diff = exp_d;
    endtask

    initial begin
        int dn;
        int dt[$];
        logic [W-1:0] dval;

        vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
        vecs[1] = '{8'h00,  8'h01,  8'hFF,  1'b1};
        vecs[2] = '{8'h5A,  8'h5A,  8'h00,  1'b0};
        vecs[3] = '{8'hFF,  8'h00,  8'hFF,  1'b0};
        vecs[4] = '{8'd3,   8'd200, 8'h3B,  1'b1};
        vecs[5] = '{8'h80,  8'h7F,  8'h01,  1'b0};
        vecs[6] = '{8'h10,  8'h20,  8'hF0,  1'b1};
        vecs[7] = '{8'hC3,  8'h41,  8'h82,  1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_borrow", 32'(borrow), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, sat(vecs[i].raw_diff, vecs[i].exp_borrow),
                   vecs[i].exp_borrow, $sformatf("vec%0d", i));
        end

        // start held high continuously: one result every W+2 clocks.
        @(negedge clk);
        a     = 8'd9;
        b     = 8'd4;
        start = 1'b1;
        dn    = 0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (done) begin
                dt.push_back(t);
                chk("b2b_diff", 32'(diff), 32'd5);
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(dt.size()), 32'd3);
        for (int k = 0; k < dt.size() && k < 3; k++) begin
            chk("b2b_time", 32'(dt[k]), 32'(9 + 10 * k));
        end
        last_diff = 8'd5;
        @(negedge clk);

        // start pulses mid-SHIFT and in DONE are ignored.
        @(negedge clk);
        a     = 8'h30;
        b     = 8'h10;
        start = 1'b1;
        dn    = 0;
        dval  = '0;
        for (int t = 1; t <= 25; t++) begin
            @(negedge clk);
            start = (t == 3 || t == 9);
            if (done) begin
                dn++;
                if (t != 9) chk("ignore_done_time", 32'(t), 32'd9);
                dval = diff;
            end
        end
        start = 1'b0;
        chk("ignore_done_count", 32'(dn), 32'd1);
        chk("ignore_diff", 32'(dval), 32'h20);
        last_diff = 8'h20;

        // Operand changes after accept do not disturb the running operation.
        @(negedge clk);
        a     = 8'h40;
        b     = 8'h05;
        start = 1'b1;
        dn    = 0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
            if (t == 2) begin a = 8'hFF; b = 8'hFF; end
            if (t == 5) begin a = 8'h00; b = 8'h77; end
            if (done) begin
                dn++;
                chk("capture_diff", 32'(diff), 32'h3B);
                chk("capture_borrow", 32'(borrow), 32'd0);
            end
        end
        chk("capture_done_count", 32'(dn), 32'd1);
        last_diff = 8'h3B;

        // Reset during the 4th SHIFT cycle clears outputs at once and produces no done.
        run_op(8'd200, 8'd1, 8'd199, 1'b0, "pre_rst");
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h03;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dn  = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("midrst_no_done", 32'(dn), 32'd0);
        last_diff = '0;
        run_op(8'h10, 8'h03, 8'h0D, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
